// File: rtl/load_align_unit_pkg.sv
// Shared definitions for the load path: load-type encodings, FSM states and
// the alignment rule used when a request is accepted.
package load_align_unit_pkg;

  typedef enum logic [2:0] {
    LT_LW  = 3'b000,
    LT_LH  = 3'b001,
    LT_LHU = 3'b010,
    LT_LB  = 3'b011,
    LT_LBU = 3'b100
  } load_type_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // True when the address cannot be served by this load type, or the type
  // itself is not a legal encoding.
  function automatic logic is_misaligned(input logic [1:0] addr_lo,
                                         input logic [2:0] load_type);
    logic bad;
    case (load_type)
      LT_LW:         bad = (addr_lo != 2'b00);
      LT_LH, LT_LHU: bad = addr_lo[0];
      LT_LB, LT_LBU: bad = 1'b0;
      default:       bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/load_align_unit_if.sv
// Request/response and data-memory read signals of the load unit.
interface load_align_unit_if;
  logic        Start;
  logic [31:0] Addr;
  logic [2:0]  LoadType;
  logic        Busy;
  logic        MemRdReq;
  logic [31:0] MemAddr;
  logic [31:0] MemRdData;
  logic        MemRdValid;
  logic [31:0] LoadData;
  logic        LoadValid;
  logic        MisalignErr;
  logic        TimeoutErr;

  // The load unit itself.
  modport slave (
    input  Start, Addr, LoadType, MemRdData, MemRdValid,
    output Busy, MemRdReq, MemAddr, LoadData, LoadValid, MisalignErr, TimeoutErr
  );

  // The pipeline / memory side driving the load unit.
  modport master (
    output Start, Addr, LoadType, MemRdData, MemRdValid,
    input  Busy, MemRdReq, MemAddr, LoadData, LoadValid, MisalignErr, TimeoutErr
  );
endinterface

// File: rtl/load_align_unit_lane_extract.sv
// Combinational lane select and extension of a little-endian memory word.
// Also used by the forwarding path, so it holds no state.
module load_lane_extract
  import load_align_unit_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  load_type,
  output logic [31:0] result
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Pick the addressed byte/halfword, then extend according to the type.
  always_comb begin
    byte_lane = 8'h00;
    half_lane = 16'h0000;
    result    = 32'h0;
    case (addr_lo)
      2'd0:    byte_lane = word[7:0];
      2'd1:    byte_lane = word[15:8];
      2'd2:    byte_lane = word[23:16];
      default: byte_lane = word[31:24];
    endcase
    half_lane = addr_lo[1] ? word[31:16] : word[15:0];
    case (load_type)
      LT_LW:   result = word;
      LT_LH:   result = {{16{half_lane[15]}}, half_lane};
      LT_LHU:  result = {16'h0000, half_lane};
      LT_LB:   result = {{24{byte_lane[7]}}, byte_lane};
      LT_LBU:  result = {24'h000000, byte_lane};
      default: result = 32'h0;
    endcase
  end

endmodule

// File: rtl/load_align_unit.sv
// MEM-stage load controller: one outstanding word-aligned read, lane extract
// with extension, misalignment and timeout reporting.
//
// state | meaning
// IDLE  | ready; Start registers the request and its alignment check
// REQ   | read strobe to memory (suppressed for a bad request), counter cleared
// WAIT  | waiting for MemRdValid, timeout counter running
// DONE  | LoadValid pulse with error flags
//
// A bad request still passes through REQ (without strobing memory) so that
// its error response lands one cycle after the request cycle, as callers
// expect; it never enters WAIT.
module load_align_unit
  import load_align_unit_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input logic               Clk,
  input logic               Reset_n,
  load_align_unit_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e            state_q, state_d;
  logic [1:0]        addr_lo_q;
  logic [2:0]        type_q;
  logic              mis_q;
  logic              to_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [31:0]       mem_addr_q;
  logic [31:0]       load_data_q;
  logic [31:0]       extracted;

  load_lane_extract u_extract (
    .word      (bus.MemRdData),
    .addr_lo   (addr_lo_q),
    .load_type (type_q),
    .result    (extracted)
  );

  // State register.
  always_ff @(posedge Clk) begin
    if (!Reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (bus.Start) state_d = ST_REQ;
      ST_REQ:  state_d = mis_q ? ST_DONE : ST_WAIT;
      ST_WAIT: if (bus.MemRdValid || (cnt_q == CNT_LAST)) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from state; flags are only visible alongside LoadValid.
  always_comb begin
    bus.Busy        = (state_q != ST_IDLE);
    bus.MemRdReq    = (state_q == ST_REQ) && !mis_q;
    bus.LoadValid   = (state_q == ST_DONE);
    bus.MisalignErr = (state_q == ST_DONE) && mis_q;
    bus.TimeoutErr  = (state_q == ST_DONE) && to_q;
    bus.MemAddr     = mem_addr_q;
    bus.LoadData    = load_data_q;
  end

  // Request capture, timeout counter and result register.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      addr_lo_q   <= 2'b00;
      type_q      <= 3'b000;
      mis_q       <= 1'b0;
      to_q        <= 1'b0;
      cnt_q       <= '0;
      mem_addr_q  <= 32'h0;
      load_data_q <= 32'h0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          mis_q <= 1'b0;
          to_q  <= 1'b0;
          if (bus.Start) begin
            addr_lo_q   <= bus.Addr[1:0];
            type_q      <= bus.LoadType;
            mem_addr_q  <= {bus.Addr[31:2], 2'b00};
            load_data_q <= 32'h0;
            mis_q       <= is_misaligned(bus.Addr[1:0], bus.LoadType);
          end
        end
        ST_REQ: cnt_q <= '0;
        ST_WAIT: begin
          if (bus.MemRdValid)       load_data_q <= extracted;
          else if (cnt_q == CNT_LAST) to_q      <= 1'b1;
          else                      cnt_q       <= cnt_q + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_align_unit.sv
// Directed bench for load_align_unit: stimulus pushes expected completions
// into a scoreboard queue; a negedge monitor pops and compares on LoadValid.
module tb_load_align_unit;
  import load_align_unit_pkg::*;

  localparam int TO = 16;

  typedef struct {
    logic [31:0] data;
    logic        mis;
    logic        to;
    int          cyc;
  } exp_t;

  logic clk;
  logic reset_n;
  int   cyc;
  int   req_cnt;
  int   n_checks;
  int   n_fail;
  exp_t sb[$];

  load_align_unit_if bus ();

  load_align_unit #(.TIMEOUT_CYCLES(TO), .CNT_W(5)) dut (
    .Clk     (clk),
    .Reset_n (reset_n),
    .bus     (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: counts memory strobes and scores every completion.
  always @(negedge clk) begin
    if (bus.MemRdReq === 1'b1) req_cnt++;
    if (bus.LoadValid === 1'b1) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_loadvalid: got LoadValid=1 expected none (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("load_data",    bus.LoadData,    e.data);
        check("misalign_err", bus.MisalignErr, e.mis);
        check("timeout_err",  bus.TimeoutErr,  e.to);
        check("valid_cycle",  cyc,             e.cyc);
      end
    end
  end

  task automatic wait_idle(input string name);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.Busy === 1'b0) return;
    end
    n_checks++;
    n_fail++;
    $display("FAIL %s: got Busy stuck high expected idle within 40 cycles", name);
  endtask

  // delay: WAIT cycles before MemRdValid; -1 = never respond.
  task automatic do_load(input string name, input logic [31:0] addr, input logic [2:0] lt,
                         input logic [31:0] word, input int delay,
                         input logic [31:0] exp_data, input logic exp_mis, input logic exp_to);
    exp_t e;
    int n;
    int req0;
    @(negedge clk);
    req0         = req_cnt;
    bus.Start    = 1'b1;
    bus.Addr     = addr;
    bus.LoadType = lt;
    n            = cyc;
    e.data = exp_data;
    e.mis  = exp_mis;
    e.to   = exp_to;
    e.cyc  = exp_mis ? n + 2 : (exp_to ? n + 2 + TO : n + 3 + delay);
    sb.push_back(e);
    @(posedge clk); #1;
    bus.Start = 1'b0;
    if (!exp_mis) begin
      @(negedge clk);
      check({name, "_memrdreq"}, bus.MemRdReq, 1'b1);
      check({name, "_memaddr"},  bus.MemAddr,  {addr[31:2], 2'b00});
      if (delay >= 0) begin
        @(posedge clk); #1;
        repeat (delay) begin @(posedge clk); #1; end
        bus.MemRdValid = 1'b1;
        bus.MemRdData  = word;
        @(posedge clk); #1;
        bus.MemRdValid = 1'b0;
      end
    end
    wait_idle(name);
    check({name, "_req_count"}, req_cnt - req0, exp_mis ? 0 : 1);
  endtask

  initial begin
    int n;
    exp_t e;
    n_checks = 0;
    n_fail   = 0;
    req_cnt  = 0;
    reset_n        = 1'b0;
    bus.Start      = 1'b1;
    bus.Addr       = 32'h104;
    bus.LoadType   = LT_LW;
    bus.MemRdData  = 32'h0;
    bus.MemRdValid = 1'b0;

    // Reset with Start held high.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy",      bus.Busy,        1'b0);
    check("rst_memrdreq",  bus.MemRdReq,    1'b0);
    check("rst_loadvalid", bus.LoadValid,   1'b0);
    check("rst_loaddata",  bus.LoadData,    32'h0);
    check("rst_memaddr",   bus.MemAddr,     32'h0);
    check("rst_mis",       bus.MisalignErr, 1'b0);
    check("rst_to",        bus.TimeoutErr,  1'b0);
    bus.Start = 1'b0;
    reset_n   = 1'b1;

    // Lane extraction and extension.
    do_load("lb_103",  32'h103, LT_LB,  32'h80FF_7F01, 0, 32'hFFFF_FF80, 1'b0, 1'b0);
    do_load("lbu_103", 32'h103, LT_LBU, 32'h80FF_7F01, 0, 32'h0000_0080, 1'b0, 1'b0);
    do_load("lhu_102", 32'h102, LT_LHU, 32'h80FF_7F01, 0, 32'h0000_80FF, 1'b0, 1'b0);
    do_load("lh_100",  32'h100, LT_LH,  32'h80FF_7F01, 0, 32'h0000_7F01, 1'b0, 1'b0);
    do_load("lh_102",  32'h102, LT_LH,  32'h80FF_7F01, 2, 32'hFFFF_80FF, 1'b0, 1'b0);
    do_load("lb_101",  32'h101, LT_LB,  32'h80FF_7F01, 1, 32'h0000_007F, 1'b0, 1'b0);
    do_load("lbu_102", 32'h102, LT_LBU, 32'h80FF_7F01, 0, 32'h0000_00FF, 1'b0, 1'b0);
    do_load("lw_104",  32'h104, LT_LW,  32'hCAFE_F00D, 3, 32'hCAFE_F00D, 1'b0, 1'b0);

    // Alignment and illegal-type errors: no memory strobe, result zero.
    do_load("lw_101",  32'h101, LT_LW,  32'h0, 0, 32'h0, 1'b1, 1'b0);
    do_load("lhu_103", 32'h103, LT_LHU, 32'h0, 0, 32'h0, 1'b1, 1'b0);
    do_load("ill_100", 32'h100, 3'b111, 32'h0, 0, 32'h0, 1'b1, 1'b0);

    // Timeout, then a late response in IDLE is ignored.
    do_load("lw_tmo",  32'h200, LT_LW,  32'h0, -1, 32'h0, 1'b0, 1'b1);
    @(negedge clk);
    bus.MemRdValid = 1'b1;
    bus.MemRdData  = 32'h5555_AAAA;
    @(negedge clk);
    bus.MemRdValid = 1'b0;
    check("late_valid_busy", bus.Busy, 1'b0);
    do_load("lw_after", 32'h204, LT_LW, 32'hDEAD_BEEF, 0, 32'hDEAD_BEEF, 1'b0, 1'b0);

    // Start pulsed during WAIT is ignored.
    @(negedge clk);
    bus.Start    = 1'b1;
    bus.Addr     = 32'h300;
    bus.LoadType = LT_LW;
    n = cyc;
    e.data = 32'h1234_5678; e.mis = 1'b0; e.to = 1'b0; e.cyc = n + 5;
    sb.push_back(e);
    @(posedge clk); #1;
    bus.Start = 1'b0;
    @(posedge clk); #1;
    bus.Start    = 1'b1;
    bus.Addr     = 32'h401;
    bus.LoadType = LT_LB;
    @(posedge clk); #1;
    bus.Start = 1'b0;
    @(negedge clk);
    check("wait_start_memaddr", bus.MemAddr, 32'h300);
    check("wait_start_busy",    bus.Busy,    1'b1);
    @(posedge clk); #1;
    bus.MemRdValid = 1'b1;
    bus.MemRdData  = 32'h1234_5678;
    @(posedge clk); #1;
    bus.MemRdValid = 1'b0;
    wait_idle("wait_start");

    // Reset during WAIT aborts silently.
    @(negedge clk);
    bus.Start    = 1'b1;
    bus.Addr     = 32'h500;
    bus.LoadType = LT_LW;
    @(posedge clk); #1;
    bus.Start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    check("midrst_busy",     bus.Busy,     1'b0);
    check("midrst_memaddr",  bus.MemAddr,  32'h0);
    check("midrst_loaddata", bus.LoadData, 32'h0);
    repeat (3) @(negedge clk);
    do_load("lhu_post", 32'h606, LT_LHU, 32'hBEEF_0123, 1, 32'h0000_BEEF, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got simulation still running expected finish");
    $fatal(1, "bench time limit");
  end

endmodule
